// File: rtl/dbuf_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// dbuf_frame_sequencer_if
//
// Purpose: groups the line-drawer handshake and the frame-buffer port bus of
// the double-buffer frame sequencer into one bundle.
//
// Signals:
//   draw_we, draw_addr, draw_data   line-drawer pixel write request
//   draw_done                       line drawer finished the frame (pulse)
//   draw_start                      back buffer cleared, drawer may write (pulse)
//   vga_addr                        VGA scan address (read side)
//   fb_we, fb_wr_addr, fb_wr_data   frame-buffer write port, address = {bank, addr}
//   fb_rd_addr                      frame-buffer read address = {front_bank, vga_addr}
//
// Modports:
//   master  the sequencer: consumes draw requests, drives the frame-buffer port
//   slave   the environment: line drawer, VGA scanner and frame-buffer memory
// ---------------------------------------------------------------------------
interface dbuf_frame_sequencer_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 6
) ();

    logic              draw_we;
    logic [ADDR_W-1:0] draw_addr;
    logic [DATA_W-1:0] draw_data;
    logic              draw_done;
    logic              draw_start;
    logic [ADDR_W-1:0] vga_addr;
    logic              fb_we;
    logic [ADDR_W:0]   fb_wr_addr;
    logic [DATA_W-1:0] fb_wr_data;
    logic [ADDR_W:0]   fb_rd_addr;

    modport master (
        input  draw_we, draw_addr, draw_data, draw_done, vga_addr,
        output draw_start, fb_we, fb_wr_addr, fb_wr_data, fb_rd_addr
    );

    modport slave (
        output draw_we, draw_addr, draw_data, draw_done, vga_addr,
        input  draw_start, fb_we, fb_wr_addr, fb_wr_data, fb_rd_addr
    );

endinterface

// File: rtl/dbuf_frame_sequencer.sv
// ---------------------------------------------------------------------------
// dbuf_frame_sequencer
//
// Purpose: per-frame controller for a double-buffered frame buffer
// (640x480, RGB 2:2:2 by default). Each frame it clears the back bank, hands
// the single write port to the line drawer, waits for vertical sync and then
// swaps the banks. VGA reads always target the front bank, writes always the
// back bank.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start_frame    pulse: begin a frame (only honoured when idle)
//   v_sync         VGA vertical sync, already synchronous to clk
//   clr_color      clear colour, only used with DBUF_CLEAR_COLOR_EN
//   front_bank     bank currently displayed
//   busy           high whenever a frame is in progress
//   frame_drop     pulse: vertical sync arrived before the frame was ready
//   draw_err       sticky: drawer wrote while it did not own the port
//   bus            draw handshake + frame-buffer port (master modport)
//
// Configuration macro:
//   DBUF_CLEAR_COLOR_EN  defined: clr_color is captured on start_frame and
//                        used as the fill colour; undefined: fill is zero.
// ---------------------------------------------------------------------------
module dbuf_frame_sequencer #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 6,
    parameter int PIX_COUNT = 307200,
    parameter bit VS_POL    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_frame,
    input  logic              v_sync,
    input  logic [DATA_W-1:0] clr_color,
    output logic              front_bank,
    output logic              busy,
    output logic              frame_drop,
    output logic              draw_err,
    dbuf_frame_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        DRAW,
        WAIT_VS,
        SWAP
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_COUNT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              front_q, front_d;
    logic              vs_q;
    logic              vs_edge;
    logic              draw_start_q, draw_start_d;
    logic              frame_drop_q, frame_drop_d;
    logic              draw_err_q, draw_err_d;
    logic              we_q, we_d;
    logic [ADDR_W:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] fill;

`ifdef DBUF_CLEAR_COLOR_EN
    logic [DATA_W-1:0] fill_q, fill_d;

    // Fill colour is frozen at start_frame so a mid-clear change of
    // clr_color cannot produce a two-tone back buffer.
    always_comb begin
        fill_d = fill_q;
        if (state_q == IDLE && start_frame) begin
            fill_d = clr_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fill = fill_q;
`else
    logic unused_clr_color;

    assign unused_clr_color = ^clr_color;
    assign fill             = '0;
`endif

    // Edge into the active sync level. The history flop resets to the
    // inactive level so a sync line idling inactive never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= ~VS_POL;
        end else begin
            vs_q <= v_sync;
        end
    end

    assign vs_edge = (v_sync == VS_POL) && (vs_q != VS_POL);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            front_q      <= 1'b0;
            draw_start_q <= 1'b0;
            frame_drop_q <= 1'b0;
            draw_err_q   <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            front_q      <= front_d;
            draw_start_q <= draw_start_d;
            frame_drop_q <= frame_drop_d;
            draw_err_q   <= draw_err_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next-state logic. Drawer writes are only captured in DRAW, so anything
    // the drawer does in other states never reaches the frame buffer; it only
    // raises the sticky error flag. The clear counter stops at the last
    // address instead of wrapping.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        front_d      = front_q;
        draw_start_d = 1'b0;
        frame_drop_d = 1'b0;
        draw_err_d   = draw_err_q | (bus.draw_we && (state_q != DRAW));
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE: begin
                if (start_frame) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                if (vs_edge) begin
                    frame_drop_d = 1'b1;
                end
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d      = DRAW;
                    draw_start_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            DRAW: begin
                if (vs_edge) begin
                    frame_drop_d = 1'b1;
                end
                we_d = bus.draw_we;
                if (bus.draw_we) begin
                    waddr_d = {~front_q, bus.draw_addr};
                    wdata_d = bus.draw_data;
                end
                if (bus.draw_done) begin
                    state_d = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vs_edge) begin
                    state_d = SWAP;
                    front_d = ~front_q;
                end
            end
            SWAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write-port mux: the clear engine owns the port in CLEAR; otherwise the
    // port shows the drawer pipeline, whose last pixel may land in the first
    // WAIT_VS cycle.
    always_comb begin
        if (state_q == CLEAR) begin
            bus.fb_we      = 1'b1;
            bus.fb_wr_addr = {~front_q, clr_cnt_q};
            bus.fb_wr_data = fill;
        end else begin
            bus.fb_we      = we_q;
            bus.fb_wr_addr = waddr_q;
            bus.fb_wr_data = wdata_q;
        end
    end

    assign bus.fb_rd_addr = {front_q, bus.vga_addr};
    assign bus.draw_start = draw_start_q;
    assign front_bank     = front_q;
    assign busy           = (state_q != IDLE);
    assign frame_drop     = frame_drop_q;
    assign draw_err       = draw_err_q;

endmodule

// File: tb/tb_dbuf_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dbuf_frame_sequencer
//
// Purpose: self-checking bench for dbuf_frame_sequencer. Every expected
// frame-buffer write is queued when the stimulus is driven and compared when
// the DUT raises fb_we. A reduced PIX_COUNT keeps the clears short.
// ---------------------------------------------------------------------------
module tb_dbuf_frame_sequencer;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 6;
    localparam int PIX    = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_frame = 1'b0;
    logic              v_sync = 1'b1;
    logic [DATA_W-1:0] clr_color = '0;
    logic              front_bank;
    logic              busy;
    logic              frame_drop;
    logic              draw_err;

    int          total = 0;
    int          bad = 0;
    int          dropCount = 0;
    logic [31:0] sbQ[$];
    logic        expFront = 1'b0;

    dbuf_frame_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busIf ();

    dbuf_frame_sequencer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .PIX_COUNT(PIX),
        .VS_POL(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_frame(start_frame),
        .v_sync(v_sync),
        .clr_color(clr_color),
        .front_bank(front_bank),
        .busy(busy),
        .frame_drop(frame_drop),
        .draw_err(draw_err),
        .bus(busIf)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic bank, input logic [ADDR_W-1:0] a,
                                         input logic [DATA_W-1:0] d);
        return {6'd0, bank, a, d};
    endfunction

    // Write monitor: each fb_we cycle pops one expected write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_drop) begin
                dropCount++;
            end
            if (busIf.fb_we) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedWrite",
                                {6'd0, busIf.fb_wr_addr, busIf.fb_wr_data}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("fbWrite",
                                {6'd0, busIf.fb_wr_addr, busIf.fb_wr_data}, sbQ.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses start_frame and queues the whole expected clear of the back bank.
    // clr_color is changed right after the pulse to prove it is sampled once.
    task automatic applyStimulus(input logic [DATA_W-1:0] col);
        logic [DATA_W-1:0] f;
`ifdef DBUF_CLEAR_COLOR_EN
        f = col;
`else
        f = '0;
`endif
        for (int i = 0; i < PIX; i++) begin
            sbQ.push_back(pack(~expFront, ADDR_W'(i), f));
        end
        start_frame = 1'b1;
        clr_color   = col;
        tick(1);
        start_frame = 1'b0;
        clr_color   = 6'h11;
    endtask

    // Counts cycles from CLEAR entry until draw_start, with a bounded wait.
    // Injects a redundant start_frame and optionally a v_sync edge mid-clear.
    task automatic waitDrawStart(input bit vsDrop);
        int n;
        for (n = 0; n < PIX + 20; n++) begin
            @(negedge clk);
            if (busIf.draw_start) break;
            start_frame = (n == 10);
            if (vsDrop && n == 5) v_sync = 1'b0;
            if (vsDrop && n == 8) v_sync = 1'b1;
            @(posedge clk);
        end
        start_frame = 1'b0;
        checkOutput("drawStartLatency", 32'(n), 32'(PIX));
    endtask

    task automatic drawPixel(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic done);
        @(posedge clk);
        #1;
        busIf.draw_we   = 1'b1;
        busIf.draw_addr = a;
        busIf.draw_data = d;
        busIf.draw_done = done;
        sbQ.push_back(pack(~expFront, a, d));
        tick(1);
        busIf.draw_we   = 1'b0;
        busIf.draw_done = 1'b0;
    endtask

    initial begin
        busIf.draw_we   = 1'b0;
        busIf.draw_addr = '0;
        busIf.draw_data = '0;
        busIf.draw_done = 1'b0;
        busIf.vga_addr  = '0;

        // Reset state
        tick(3);
        checkOutput("rstFbWe", 32'(busIf.fb_we), 32'd0);
        checkOutput("rstWrAddr", 32'(busIf.fb_wr_addr), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstFront", 32'(front_bank), 32'd0);
        checkOutput("rstDrawStart", 32'(busIf.draw_start), 32'd0);
        checkOutput("rstDrop", 32'(frame_drop), 32'd0);
        checkOutput("rstErr", 32'(draw_err), 32'd0);
        checkOutput("rstRdAddr", 32'(busIf.fb_rd_addr), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Frame 1: clear bank 1, two pixels, the second with draw_done, swap
        $display("[TB] frame 1");
        applyStimulus(6'h3F);
        waitDrawStart(1'b0);
        checkOutput("f1BusyDraw", 32'(busy), 32'd1);
        drawPixel(19'd5, 6'h2A, 1'b0);
        drawPixel(19'd7, 6'h15, 1'b1);
        tick(3);
        checkOutput("f1WaitBusy", 32'(busy), 32'd1);
        checkOutput("f1WaitFront", 32'(front_bank), 32'd0);
        checkOutput("f1SbEmpty", 32'(sbQ.size()), 32'd0);
        v_sync = 1'b0;
        busIf.vga_addr = 19'd123;
        tick(1);
        expFront = 1'b1;
        checkOutput("f1SwapFront", 32'(front_bank), 32'(expFront));
        checkOutput("f1SwapBusy", 32'(busy), 32'd1);
        checkOutput("f1RdAddr", 32'(busIf.fb_rd_addr), {12'd0, 1'b1, 19'd123});
        tick(1);
        checkOutput("f1IdleBusy", 32'(busy), 32'd0);
        checkOutput("f1Drops", 32'(dropCount), 32'd0);
        v_sync = 1'b1;
        tick(2);

        // Reset in the middle of a clear of bank 0
        $display("[TB] reset mid-clear");
        applyStimulus(6'h00);
        tick(20);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstFbWe", 32'(busIf.fb_we), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstFront", 32'(front_bank), 32'd0);
        checkOutput("midRstWrAddr", 32'(busIf.fb_wr_addr), 32'd0);
        sbQ.delete();
        expFront = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Frame 2: v_sync edge during CLEAR, then draw_done together with v_sync
        $display("[TB] frame 2");
        applyStimulus(6'h3F);
        waitDrawStart(1'b1);
        checkOutput("f2DropClear", 32'(dropCount), 32'd1);
        checkOutput("f2FrontKept", 32'(front_bank), 32'd0);
        drawPixel(19'd9, 6'h3C, 1'b0);
        @(posedge clk);
        #1;
        busIf.draw_done = 1'b1;
        v_sync = 1'b0;
        tick(1);
        busIf.draw_done = 1'b0;
        tick(3);
        checkOutput("f2DropDone", 32'(dropCount), 32'd2);
        checkOutput("f2NoSwapFront", 32'(front_bank), 32'd0);
        checkOutput("f2NoSwapBusy", 32'(busy), 32'd1);
        v_sync = 1'b1;
        tick(2);
        v_sync = 1'b0;
        tick(1);
        expFront = 1'b1;
        checkOutput("f2SwapFront", 32'(front_bank), 32'(expFront));
        tick(1);
        checkOutput("f2IdleBusy", 32'(busy), 32'd0);
        v_sync = 1'b1;
        checkOutput("f2ErrClean", 32'(draw_err), 32'd0);

        // Drawer write while idle: error flag, no frame-buffer write
        $display("[TB] idle write");
        busIf.draw_we   = 1'b1;
        busIf.draw_addr = 19'd3;
        tick(1);
        busIf.draw_we = 1'b0;
        checkOutput("idleErr", 32'(draw_err), 32'd1);
        checkOutput("idleFbWe", 32'(busIf.fb_we), 32'd0);
        tick(5);
        checkOutput("idleErrSticky", 32'(draw_err), 32'd1);

        checkOutput("finalSbEmpty", 32'(sbQ.size()), 32'd0);
        checkOutput("finalDrops", 32'(dropCount), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
